// File: rtl/mem_req_buffer_pkg.sv
// Shared types for the arbiter-to-memory request buffer: command and write-beat payloads.
// Fallback widths apply only when the shared memory defines header has not been read first.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 8
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif

package mem_req_buffer_pkg;

  localparam int unsigned ADDR_W = `MEM_ADDR_BITS;
  localparam int unsigned TAG_W  = `MEM_TAG_BITS;
  localparam int unsigned DATA_W = `MEM_DATA_BITS;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] bits;
    logic [MASK_W-1:0] mask;
  } wdata_t;

endpackage

// File: rtl/mem_req_buffer_fifo.sv
// Synchronous FIFO with registered storage (no fall-through); pointers carry an extra wrap bit.
module mem_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; empty/full gate every use of its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/mem_req_buffer.sv
// Decouples the arbiter port from memory: queued commands, write beats released only behind
// their issued command, capped outstanding reads, and a one-cycle registered response path.
module mem_req_buffer
  import mem_req_buffer_pkg::*;
#(
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned DATA_DEPTH = 8,
  parameter int unsigned DATA_BEATS = 4,
  parameter int unsigned MAX_RD     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_req_valid,
  output logic              up_req_ready,
  input  logic              up_req_rw,
  input  logic [ADDR_W-1:0] up_req_addr,
  input  logic [TAG_W-1:0]  up_req_tag,
  input  logic              up_data_valid,
  output logic              up_data_ready,
  input  logic [DATA_W-1:0] up_data_bits,
  input  logic [MASK_W-1:0] up_data_mask,
  output logic              up_resp_valid,
  output logic [DATA_W-1:0] up_resp_data,
  output logic [TAG_W-1:0]  up_resp_tag,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [TAG_W-1:0]  mem_req_tag,
  output logic              mem_req_data_valid,
  input  logic              mem_req_data_ready,
  output logic [DATA_W-1:0] mem_req_data_bits,
  output logic [MASK_W-1:0] mem_req_data_mask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic [TAG_W-1:0]  mem_resp_tag
);

  localparam int unsigned CCW = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned DCW = $clog2(DATA_DEPTH) + 1;
  localparam int unsigned BW  = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam int unsigned RW  = 4;

  cmd_t            cmd_in, cmd_head;
  wdata_t          dat_in, dat_head;
  logic            cmd_full, cmd_empty, data_full, data_empty;
  logic [CCW-1:0]  cmd_count;
  logic [DCW-1:0]  data_count;
  logic            cmd_push, cmd_pop, data_push, data_pop;
  logic            issue_gate, rd_inc, beat_last;
  logic [DCW-1:0]  credit_q, credit_d;
  logic [RW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            unused_fifo_status;

  assign cmd_in    = '{rw: up_req_rw, addr: up_req_addr, tag: up_req_tag};
  assign dat_in    = '{bits: up_data_bits, mask: up_data_mask};
  assign cmd_push  = up_req_valid && !cmd_full;
  assign data_push = up_data_valid && !data_full;

  mem_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (cmd_push),
    .wdata_i (cmd_in),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_count)
  );

  mem_fifo #(.WIDTH($bits(wdata_t)), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (data_push),
    .wdata_i (dat_in),
    .pop_i   (data_pop),
    .rdata_o (dat_head),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (data_count)
  );

  // Data emptiness is implied by credit; command occupancy only matters through full/empty.
  assign unused_fifo_status = ^{cmd_count, data_empty};

  // A write may issue only once all of its beats sit behind beats already promised to earlier writes.
  always_comb begin
    issue_gate = 1'b0;
    if (cmd_head.rw) issue_gate = 32'(data_count) >= 32'(DATA_BEATS) + 32'(credit_q);
    else             issue_gate = 32'(rd_cnt_q) < 32'(MAX_RD);
  end

  assign up_req_ready       = !cmd_full;
  assign up_data_ready      = !data_full;
  assign mem_req_valid      = !cmd_empty && issue_gate;
  assign cmd_pop            = mem_req_valid && mem_req_ready;
  assign mem_req_rw         = cmd_head.rw;
  assign mem_req_addr       = cmd_head.addr;
  assign mem_req_tag        = cmd_head.tag;
  assign mem_req_data_valid = (credit_q != '0);
  assign data_pop           = mem_req_data_valid && mem_req_data_ready;
  assign mem_req_data_bits  = dat_head.bits;
  assign mem_req_data_mask  = dat_head.mask;

  assign rd_inc    = cmd_pop && !cmd_head.rw;
  assign beat_last = mem_resp_valid && (beat_q == BW'(DATA_BEATS - 1));

  always_comb begin
    credit_d = credit_q;
    beat_d   = beat_q;
    rd_cnt_d = rd_cnt_q;
    if (cmd_pop && cmd_head.rw) credit_d = credit_d + DCW'(DATA_BEATS);
    if (data_pop)               credit_d = credit_d - DCW'(1);
    if (mem_resp_valid)         beat_d   = beat_last ? '0 : beat_q + BW'(1);
    // Completions of reads issued before a reset must not wrap the counter below zero.
    if (rd_inc && !beat_last)                          rd_cnt_d = rd_cnt_q + RW'(1);
    else if (!rd_inc && beat_last && rd_cnt_q != '0)   rd_cnt_d = rd_cnt_q - RW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q      <= '0;
      rd_cnt_q      <= '0;
      beat_q        <= '0;
      up_resp_valid <= 1'b0;
      up_resp_data  <= '0;
      up_resp_tag   <= '0;
    end else begin
      credit_q      <= credit_d;
      rd_cnt_q      <= rd_cnt_d;
      beat_q        <= beat_d;
      up_resp_valid <= mem_resp_valid;
      up_resp_data  <= mem_resp_data;
      up_resp_tag   <= mem_resp_tag;
    end
  end

endmodule

// File: tb/tb_mem_req_buffer.sv
// Bench for mem_req_buffer: a response-path vector table, directed corner sequences and a
// randomized run, all checked against a queue-based model of the buffer's rules.
module tb_mem_req_buffer;
  import mem_req_buffer_pkg::*;

  localparam int unsigned CMD_DEPTH  = 4;
  localparam int unsigned DATA_DEPTH = 8;
  localparam int unsigned DATA_BEATS = 4;
  localparam int unsigned MAX_RD     = 4;

  logic clk = 1'b0;
  logic reset;
  logic up_req_valid, up_req_ready, up_req_rw;
  logic [ADDR_W-1:0] up_req_addr;
  logic [TAG_W-1:0]  up_req_tag;
  logic up_data_valid, up_data_ready;
  logic [DATA_W-1:0] up_data_bits;
  logic [MASK_W-1:0] up_data_mask;
  logic up_resp_valid;
  logic [DATA_W-1:0] up_resp_data;
  logic [TAG_W-1:0]  up_resp_tag;
  logic mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [TAG_W-1:0]  mem_req_tag;
  logic mem_req_data_valid, mem_req_data_ready;
  logic [DATA_W-1:0] mem_req_data_bits;
  logic [MASK_W-1:0] mem_req_data_mask;
  logic mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic [TAG_W-1:0]  mem_resp_tag;

  always #5 clk = ~clk;

  mem_req_buffer #(
    .CMD_DEPTH(CMD_DEPTH), .DATA_DEPTH(DATA_DEPTH), .DATA_BEATS(DATA_BEATS), .MAX_RD(MAX_RD)
  ) dut (
    .clk(clk), .reset(reset),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_rw(up_req_rw),
    .up_req_addr(up_req_addr), .up_req_tag(up_req_tag),
    .up_data_valid(up_data_valid), .up_data_ready(up_data_ready),
    .up_data_bits(up_data_bits), .up_data_mask(up_data_mask),
    .up_resp_valid(up_resp_valid), .up_resp_data(up_resp_data), .up_resp_tag(up_resp_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  typedef struct packed {
    logic              req_v;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic              dat_v;
    logic [DATA_W-1:0] bits;
    logic [MASK_W-1:0] mask;
    logic              mreq_rdy;
    logic              mdat_rdy;
    logic              rsp_v;
    logic [DATA_W-1:0] rsp_d;
    logic [TAG_W-1:0]  rsp_t;
  } stim_t;

  typedef struct packed {
    logic       req_v;
    logic       rsp_v;
    logic [7:0] rsp_d;
    logic       e_mv;
    logic       e_rv;
    logic [7:0] e_rd;
  } vec_t;

  stim_t s;
  vec_t  tv [8];

  // Reference model: queues of accepted commands/beats plus counts derived from the rules.
  cmd_t   cq[$];
  wdata_t dq[$];
  int     credit, rd_out, beat;
  logic              e_rv;
  logic [DATA_W-1:0] e_rd;
  logic [TAG_W-1:0]  e_rt;

  int n_pass = 0, n_total = 0;
  int n_push, n_issue, n_beat;
  logic [ADDR_W-1:0] iss_addr[$];
  wdata_t            beats[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic e_mv();
    if (cq.size() == 0) return 1'b0;
    if (cq[0].rw) return dq.size() >= int'(DATA_BEATS) + credit;
    return rd_out < int'(MAX_RD);
  endfunction

  task automatic apply();
    up_req_valid       = s.req_v;
    up_req_rw          = s.rw;
    up_req_addr        = s.addr;
    up_req_tag         = s.tag;
    up_data_valid      = s.dat_v;
    up_data_bits       = s.bits;
    up_data_mask       = s.mask;
    mem_req_ready      = s.mreq_rdy;
    mem_req_data_ready = s.mdat_rdy;
    mem_resp_valid     = s.rsp_v;
    mem_resp_data      = s.rsp_d;
    mem_resp_tag       = s.rsp_t;
  endtask

  task automatic check_model();
    chk("up_req_ready", 128'(up_req_ready), 128'(cq.size() < int'(CMD_DEPTH)));
    chk("up_data_ready", 128'(up_data_ready), 128'(dq.size() < int'(DATA_DEPTH)));
    chk("mem_req_valid", 128'(mem_req_valid), 128'(e_mv()));
    if (e_mv()) chk("mem_req_cmd", 128'({mem_req_rw, mem_req_addr, mem_req_tag}), 128'(cq[0]));
    chk("mem_req_data_valid", 128'(mem_req_data_valid), 128'(credit != 0));
    if (credit != 0 && dq.size() > 0)
      chk("mem_req_data", 128'({mem_req_data_bits, mem_req_data_mask}), 128'(dq[0]));
    chk("up_resp_valid", 128'(up_resp_valid), 128'(e_rv));
    if (e_rv) chk("up_resp_payload", 128'({up_resp_data, up_resp_tag}), 128'({e_rd, e_rt}));
  endtask

  task automatic model_update();
    logic mv, dv, req_rdy, dat_rdy, inc, done;
    cmd_t c;
    mv      = e_mv();
    dv      = (credit != 0);
    req_rdy = cq.size() < int'(CMD_DEPTH);
    dat_rdy = dq.size() < int'(DATA_DEPTH);
    inc     = 1'b0;
    done    = 1'b0;
    if (dv && s.mdat_rdy && dq.size() > 0) begin
      void'(dq.pop_front());
      credit--;
    end
    if (mv && s.mreq_rdy) begin
      c = cq.pop_front();
      if (c.rw) credit += int'(DATA_BEATS);
      else inc = 1'b1;
    end
    if (s.req_v && req_rdy) cq.push_back(cmd_t'({s.rw, s.addr, s.tag}));
    if (s.dat_v && dat_rdy) dq.push_back(wdata_t'({s.bits, s.mask}));
    if (s.rsp_v) begin
      beat++;
      if (beat == int'(DATA_BEATS)) begin
        beat = 0;
        done = 1'b1;
      end
    end
    if (inc && !done) rd_out++;
    else if (done && !inc && rd_out > 0) rd_out--;
    e_rv = s.rsp_v;
    e_rd = s.rsp_d;
    e_rt = s.rsp_t;
  endtask

  task automatic pre();
    apply();
    #1;
    check_model();
    if (s.req_v && up_req_ready) n_push++;
    if (mem_req_valid && s.mreq_rdy) begin
      n_issue++;
      iss_addr.push_back(mem_req_addr);
    end
    if (mem_req_data_valid && s.mdat_rdy) begin
      n_beat++;
      beats.push_back(wdata_t'({mem_req_data_bits, mem_req_data_mask}));
    end
  endtask

  task automatic post();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cyc();
    pre();
    post();
  endtask

  task automatic do_reset();
    s = '0;
    apply();
    reset = 1'b0;
    #1;
    chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_mem_req_data_valid", 128'(mem_req_data_valid), 128'(0));
    chk("rst_up_resp_valid", 128'(up_resp_valid), 128'(0));
    cq.delete();
    dq.delete();
    credit = 0;
    rd_out = 0;
    beat   = 0;
    e_rv   = 1'b0;
    e_rd   = '0;
    e_rt   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    n_push = 0;
    n_issue = 0;
    n_beat = 0;
    iss_addr.delete();
    beats.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    // Single read, four response beats, each returned one cycle later with the request tag.
    tv = '{
      '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00},
      '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 8'hD0, 1'b0, 1'b0, 8'h00},
      '{1'b0, 1'b1, 8'hD1, 1'b0, 1'b1, 8'hD0},
      '{1'b0, 1'b1, 8'hD2, 1'b0, 1'b1, 8'hD1},
      '{1'b0, 1'b1, 8'hD3, 1'b0, 1'b1, 8'hD2},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hD3},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}
    };

    do_reset();
    for (int i = 0; i < 8; i++) begin
      s = '0;
      s.mreq_rdy = 1'b1;
      s.req_v    = tv[i].req_v;
      s.addr     = ADDR_W'(32'h10);
      s.tag      = TAG_W'(3);
      s.rsp_v    = tv[i].rsp_v;
      s.rsp_d    = {(DATA_W/8){tv[i].rsp_d}};
      s.rsp_t    = TAG_W'(3);
      pre();
      chk($sformatf("tbl%0d_mem_req_valid", i), 128'(mem_req_valid), 128'(tv[i].e_mv));
      if (tv[i].e_mv)
        chk("tbl_mem_req_cmd", 128'({mem_req_rw, mem_req_addr, mem_req_tag}),
            128'({1'b0, ADDR_W'(32'h10), TAG_W'(3)}));
      chk($sformatf("tbl%0d_up_resp_valid", i), 128'(up_resp_valid), 128'(tv[i].e_rv));
      if (tv[i].e_rv)
        chk("tbl_up_resp_payload", 128'({up_resp_data, up_resp_tag}),
            128'({{(DATA_W/8){tv[i].e_rd}}, TAG_W'(3)}));
      post();
    end
    chk("tbl_rd_cnt_idle", 128'(dut.rd_cnt_q), 128'(0));

    // Write command waits for its fourth beat, then exactly four beats leave in order.
    do_reset();
    s = '0;
    s.mreq_rdy = 1'b1;
    s.mdat_rdy = 1'b1;
    s.req_v = 1'b1;
    s.rw = 1'b1;
    s.addr = ADDR_W'(32'h40);
    s.tag = TAG_W'(5);
    for (int i = 0; i < 3; i++) begin
      s.dat_v = 1'b1;
      s.bits = DATA_W'(64'hB0 + i);
      s.mask = MASK_W'(8'hF0 | i);
      cyc();
      s.req_v = 1'b0;
    end
    s.dat_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pre();
      chk("wr_held_3beats", 128'(mem_req_valid), 128'(0));
      post();
    end
    s.dat_v = 1'b1;
    s.bits = DATA_W'(64'hB3);
    s.mask = MASK_W'(8'hF3);
    cyc();
    s.dat_v = 1'b0;
    pre();
    chk("wr_issue_on_4th", 128'(mem_req_valid), 128'(1));
    post();
    for (int i = 0; i < 8; i++) cyc();
    chk("wr_beat_count", 128'(n_beat), 128'(4));
    for (int i = 0; i < 4 && i < beats.size(); i++)
      chk("wr_beat_order", 128'(beats[i]), 128'({DATA_W'(64'hB0 + i), MASK_W'(8'hF0 | i)}));

    // Five reads against a cap of four; the fifth issues the cycle after read 0 completes.
    do_reset();
    s = '0;
    s.mreq_rdy = 1'b1;
    for (int k = 0; k < 40 && n_push < 5; k++) begin
      s.req_v = 1'b1;
      s.addr = ADDR_W'(32'h100 + n_push);
      s.tag = TAG_W'(n_push);
      cyc();
    end
    s.req_v = 1'b0;
    repeat (4) cyc();
    chk("rdcap_pushed", 128'(n_push), 128'(5));
    chk("rdcap_issued", 128'(n_issue), 128'(4));
    s.rsp_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s.rsp_d = DATA_W'(i);
      cyc();
    end
    chk("rdcap_blocked_on_completion", 128'(n_issue), 128'(4));
    s.rsp_v = 1'b0;
    cyc();
    chk("rdcap_5th_issues", 128'(n_issue), 128'(5));

    // Full command FIFO drops ready; one pop restores it; memory sees push order.
    do_reset();
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s.req_v = 1'b1;
      s.addr = ADDR_W'(i);
      s.tag = TAG_W'(i);
      cyc();
    end
    s.req_v = 1'b0;
    pre();
    chk("full_ready_low", 128'(up_req_ready), 128'(0));
    post();
    s.mreq_rdy = 1'b1;
    cyc();
    s.mreq_rdy = 1'b0;
    pre();
    chk("ready_reasserts", 128'(up_req_ready), 128'(1));
    post();
    s.mreq_rdy = 1'b1;
    repeat (6) cyc();
    chk("order_count", 128'(iss_addr.size()), 128'(4));
    for (int i = 0; i < 4 && i < iss_addr.size(); i++)
      chk("order_addr", 128'(iss_addr[i]), 128'(i));

    // Write/read/write with the data channel toggling.
    do_reset();
    s = '0;
    s.mreq_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s.req_v = (i < 3);
      s.rw = (i != 1);
      s.addr = ADDR_W'(i + 1);
      s.tag = TAG_W'(i);
      s.dat_v = (i < 8);
      s.bits = DATA_W'(64'hC0 + i);
      s.mask = MASK_W'(i);
      s.mdat_rdy = (i % 2 == 1);
      cyc();
    end
    s = '0;
    s.mreq_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s.mdat_rdy = (i % 2 == 0);
      cyc();
    end
    chk("mix_beat_count", 128'(n_beat), 128'(8));
    for (int i = 0; i < 8 && i < beats.size(); i++)
      chk("mix_beat_order", 128'(beats[i]), 128'({DATA_W'(64'hC0 + i), MASK_W'(i)}));
    chk("mix_cmd_count", 128'(iss_addr.size()), 128'(3));
    for (int i = 0; i < 3 && i < iss_addr.size(); i++)
      chk("mix_cmd_order", 128'(iss_addr[i]), 128'(i + 1));

    // Reset after two of four write beats; afterwards only the fresh read appears.
    do_reset();
    s = '0;
    s.mreq_rdy = 1'b1;
    s.mdat_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s.req_v = (i == 0);
      s.rw = 1'b1;
      s.addr = ADDR_W'(32'h80);
      s.dat_v = 1'b1;
      s.bits = DATA_W'(64'hE0 + i);
      s.mask = '1;
      cyc();
    end
    s.req_v = 1'b0;
    s.dat_v = 1'b0;
    for (int k = 0; k < 10 && n_beat < 2; k++) cyc();
    chk("midrst_two_beats_sent", 128'(n_beat), 128'(2));
    do_reset();
    s = '0;
    s.mreq_rdy = 1'b1;
    s.mdat_rdy = 1'b1;
    s.req_v = 1'b1;
    s.addr = ADDR_W'(32'h77);
    s.tag = TAG_W'(7);
    cyc();
    s.req_v = 1'b0;
    repeat (6) cyc();
    chk("postrst_read_issued", 128'(n_issue), 128'(1));
    if (iss_addr.size() > 0) chk("postrst_read_addr", 128'(iss_addr[0]), 128'(32'h77));
    chk("postrst_no_stale_beats", 128'(n_beat), 128'(0));

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      s.req_v    = 1'($urandom_range(0, 1));
      s.rw       = 1'($urandom_range(0, 1));
      s.addr     = ADDR_W'($urandom);
      s.tag      = TAG_W'($urandom);
      s.dat_v    = ($urandom_range(0, 3) != 0);
      s.bits     = DATA_W'({$urandom, $urandom});
      s.mask     = MASK_W'($urandom);
      s.mreq_rdy = ($urandom_range(0, 3) != 0);
      s.mdat_rdy = ($urandom_range(0, 2) != 0);
      s.rsp_v    = (rd_out > 0 || beat != 0) && ($urandom_range(0, 1) == 1);
      s.rsp_d    = DATA_W'({$urandom, $urandom});
      s.rsp_t    = TAG_W'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_req_buffer.md
# mem_req_buffer

Decoupling buffer between the memory arbiter's external port and main memory (ExtMemModel / DRAM controller). It queues request commands and write-data beats in two FIFOs and releases write beats only after their command has issued. It caps in-flight read transactions and returns registered read responses to the arbiter. This isolates cache/arbiter timing from memory-side back-pressure.

## Interface
Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- DATA_DEPTH, 8, write-data FIFO entries (power of 2, ≥ DATA_BEATS)
- DATA_BEATS, 4, data beats per transaction (read or write)
- MAX_RD, 4, maximum outstanding read transactions (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- up_req_valid / up_req_ready  in/out  1/1  command handshake from arbiter
- up_req_rw  in  1  1 = write, 0 = read
- up_req_addr  in  `MEM_ADDR_BITS  transaction address
- up_req_tag  in  `MEM_TAG_BITS  transaction tag
- up_data_valid / up_data_ready  in/out  1/1  write-beat handshake from arbiter/dcache
- up_data_bits  in  `MEM_DATA_BITS  write beat
- up_data_mask  in  `MEM_DATA_BITS/8  byte enables
- up_resp_valid  out  1  registered read-response beat
- up_resp_data  out  `MEM_DATA_BITS  response data
- up_resp_tag  out  `MEM_TAG_BITS  response tag
- mem_req_valid / mem_req_ready  out/in  1/1  command handshake to memory
- mem_req_rw, mem_req_addr, mem_req_tag  out  1/`MEM_ADDR_BITS/`MEM_TAG_BITS  head-of-queue command
- mem_req_data_valid / mem_req_data_ready  out/in  1/1  write-beat handshake to memory
- mem_req_data_bits, mem_req_data_mask  out  `MEM_DATA_BITS/`MEM_DATA_BITS/8  head write beat
- mem_resp_valid  in  1  read-response beat from memory (no back-pressure)
- mem_resp_data, mem_resp_tag  in  `MEM_DATA_BITS/`MEM_TAG_BITS  response payload

## Operation
- Command FIFO stores {rw, addr, tag}; push on up_req_valid && up_req_ready. up_req_ready = !cmd_full (no pop-bypass when full).
- Data FIFO stores {bits, mask}; push on up_data_valid && up_data_ready. up_data_ready = !data_full.
- Command issue: mem_req_valid = !cmd_empty && gate. For writes, gate = data FIFO count ≥ DATA_BEATS + release_credit. For reads, gate = rd_cnt < MAX_RD. Pop on mem_req_valid && mem_req_ready.
- release_credit counter: on write issue += DATA_BEATS; on each data beat sent −= 1; simultaneous → net DATA_BEATS−1. mem_req_data_valid = release_credit != 0 (guaranteed nonempty by gate).
- rd_cnt: +1 on read issue. A resp beat counter counts mem_resp_valid beats modulo DATA_BEATS; −1 when the beat completing a transaction arrives. Simultaneous inc/dec → unchanged. Issue is blocked at rd_cnt == MAX_RD even if a completion occurs the same cycle.
- Responses: up_resp_valid/data/tag <= mem_resp_valid/data/tag every cycle (1-cycle pipeline, no stall).
- Commands issue strictly in FIFO order. A blocked head (read at cap, or write lacking beats) blocks all behind it.
- Write beats leave in push order, with no reordering relative to write commands.

## Timing
- Reset (reset = 0, async): both FIFOs empty, release_credit = 0, rd_cnt = 0, beat counter = 0, up_resp_valid = 0. up_req_ready and up_data_ready read 1 once reset = 1; all mem_req_*valid = 0. Reset mid-transaction discards all queued and in-flight state; later responses from a pre-reset read are forwarded but do not decrement rd_cnt below 0 (saturate at 0).
- Latency: a pushed command can present on mem_req_* the cycle after push at the earliest (registered FIFO, no fall-through). A pushed beat can present one cycle after push when credit exists.
- Response latency is exactly 1 cycle.
- Payload outputs are valid only with the matching valid; values otherwise don't-care.
- FIFO pointers wrap modulo depth; full/empty use an extra pointer bit.

## Structure
- Sub-module mem_fifo (parameterised WIDTH, DEPTH; outputs full, empty, count; registered output), instantiated for commands and for data.
- MEM_ADDR_BITS/MEM_TAG_BITS/MEM_DATA_BITS come from the shared memory defines header. No new shared constants.

## Test plan
- Single read addr 0x10, tag 3, mem_req_ready = 1 → mem_req_valid asserted one cycle after push. Four response beats D0..D3 → up_resp beats D0..D3 with tag 3, each one cycle later; rd_cnt returns to 0.
- Write cmd pushed with only 3 beats queued → mem_req_valid stays 0. 4th beat pushed → command issues, then exactly 4 beats leave in order with masks intact.
- Five back-to-back reads, MAX_RD = 4, no responses → 4 issue, 5th held. Completing 4 beats of read 0 → 5th issues on the following cycle.
- mem_req_ready = 0, push 4 commands → up_req_ready drops after the 4th. One pop → ready reasserts the next cycle. Order on the memory side is preserved.
- Interleave write(2 lines)/read/write with mem_req_data_ready toggling 1/0 → beat order and command order are unchanged, and release_credit never underflows.
- Assert reset low mid-write (2 of 4 beats sent) → all valids are 0 immediately. After release, a fresh read issues normally and stale beats are never emitted.
